// File: rtl/mult_arb_pkg.sv
// Shared widths, default parameters and helpers for the shared-multiplier arbiter.
package mult_arb_pkg;

   localparam int DEF_NREQ       = 4;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_MULT_LAT   = 2;
   localparam int OP_W           = 32;
   localparam int PROD_W         = 64;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_resp_fifo.sv
// First-word-fall-through result FIFO holding {id, product} entries.
module mult_resp_fifo
   import mult_arb_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int ID_W  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ID_W-1:0]            wr_id,
   input  logic [PROD_W-1:0]          wr_prod,
   input  logic                       rd_en,
   output logic [ID_W-1:0]            rd_id,
   output logic [PROD_W-1:0]          rd_prod,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ID_W+PROD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   do_wr, do_rd;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_wr    = wr_en && (count_q != CNT_W'(DEPTH));
      do_rd    = rd_en && (count_q != '0);
      wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_rd && !do_wr) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= {wr_id, wr_prod};
      end
   end

   assign rd_id   = mem_q[rd_ptr_q][ID_W+PROD_W-1:PROD_W];
   assign rd_prod = mem_q[rd_ptr_q][PROD_W-1:0];
   assign count   = count_q;
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/multiplier_32x32.sv
// Pipelined 32x32 unsigned multiplier; product appears LAT edges after operand capture.
module multiplier_32x32
   import mult_arb_pkg::*;
#(
   parameter int LAT = DEF_MULT_LAT
) (
   input  logic              clk,
   input  logic [OP_W-1:0]   mr,
   input  logic [OP_W-1:0]   mc,
   output logic [PROD_W-1:0] prod
);

   logic [PROD_W-1:0] pipe_q [LAT];
   logic [PROD_W-1:0] pipe_d [LAT];

   always_comb begin
      pipe_d[0] = PROD_W'(mr) * PROD_W'(mc);
      for (int k = 1; k < LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
   end

   // Pure datapath: validity is tracked by the arbiter's tag pipeline.
   always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
   end

   assign prod = pipe_q[LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ requesters,
// with credit-based flow control into a FWFT result FIFO.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int MULT_LAT   = DEF_MULT_LAT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*OP_W-1:0]      req_mr,
   input  logic [NREQ*OP_W-1:0]      req_mc,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [id_width(NREQ)-1:0] resp_id,
   output logic [PROD_W-1:0]         resp_prod,
   output logic                      busy
);

   localparam int ID_W   = id_width(NREQ);
   localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CRED_W-1:0] credit_q, credit_d;
   logic [MULT_LAT:1] tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]   tag_id_q [1:MULT_LAT];
   logic [ID_W-1:0]   tag_id_d [1:MULT_LAT];
   logic [ID_W-1:0]   cand, grant_id;
   logic              grant_found, accept, pop;
   logic [OP_W-1:0]   mult_mr, mult_mc;
   logic [PROD_W-1:0] mult_prod;
   logic              fifo_wr, fifo_full, fifo_empty;
   logic [CRED_W-1:0] fifo_count;
   logic [ID_W-1:0]   fifo_id;
   logic [PROD_W-1:0] fifo_prod;

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_q + ID_W'(k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   // Tag stage 0 is the accept itself; stages 1..MULT_LAT follow the multiplier.
   always_comb begin
      accept    = !rst && grant_found && (credit_q != '0);
      pop       = resp_valid && resp_ready;
      req_ready = '0;
      mult_mr   = '0;
      mult_mc   = '0;
      if (accept) begin
         req_ready[grant_id] = 1'b1;
         mult_mr = req_mr[grant_id*OP_W +: OP_W];
         mult_mc = req_mc[grant_id*OP_W +: OP_W];
      end
      ptr_d    = accept ? grant_id + ID_W'(1) : ptr_q;
      credit_d = credit_q;
      if (accept && !pop) begin
         credit_d = credit_q - CRED_W'(1);
      end else if (pop && !accept) begin
         credit_d = credit_q + CRED_W'(1);
      end
      tag_vld_d[1] = accept;
      tag_id_d[1]  = grant_id;
      for (int k = 2; k <= MULT_LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_id_d[k]  = tag_id_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         credit_q  <= CRED_W'(FIFO_DEPTH);
         tag_vld_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         credit_q  <= credit_d;
         tag_vld_q <= tag_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_id_q <= tag_id_d;
   end

   multiplier_32x32 #(
      .LAT (MULT_LAT)
   ) u_mult (
      .clk  (clk),
      .mr   (mult_mr),
      .mc   (mult_mc),
      .prod (mult_prod)
   );

   // Credits already exclude overflow; the full guard only backs that up.
   assign fifo_wr = tag_vld_q[MULT_LAT] && !fifo_full;

   mult_resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .ID_W  (ID_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_id   (tag_id_q[MULT_LAT]),
      .wr_prod (mult_prod),
      .rd_en   (pop),
      .rd_id   (fifo_id),
      .rd_prod (fifo_prod),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Reset is synchronous, so outputs are gated to be quiet in the first reset cycle too.
   assign resp_valid = !rst && !fifo_empty;
   assign resp_id    = fifo_id;
   assign resp_prod  = fifo_prod;
   assign busy       = !rst && (accept || (|tag_vld_q) || (fifo_count != '0));

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: accepts push golden products, pops compare.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int FD   = 4;
   localparam int LAT  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_mr;
   logic [NREQ*32-1:0] req_mc;
   logic              resp_valid;
   logic              resp_ready;
   logic [1:0]        resp_id;
   logic [63:0]       resp_prod;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int pop_cnt = 0;
   int model_cred = FD;
   logic [65:0] sb [$];

   always #5 clk = ~clk;

   mult_arbiter #(
      .NREQ       (NREQ),
      .FIFO_DEPTH (FD),
      .MULT_LAT   (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mr     (req_mr),
      .req_mc     (req_mc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_prod  (resp_prod),
      .busy       (busy)
   );

   // Scoreboard monitor: legality of grants, credit model, in-order results.
   always @(negedge clk) begin
      logic [65:0] exp_e;
      if (rst) begin
         sb.delete();
         model_cred = FD;
      end else begin
         checks++;
         if ($countones(req_ready) > 1 || ((req_ready & ~req_valid) != 0) ||
             (model_cred == 0 && req_ready != 0)) begin
            errors++;
            $display("FAIL grant_legal ready=%b valid=%b credits=%0d", req_ready, req_valid, model_cred);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back({2'(i), 64'(req_mr[32*i +: 32]) * 64'(req_mc[32*i +: 32])});
               acc_cnt++;
               model_cred--;
            end
         end
         if (resp_valid && resp_ready) begin
            pop_cnt++;
            model_cred++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected id=%0d prod=%0d expected none", resp_id, resp_prod);
            end else begin
               exp_e = sb.pop_front();
               if ({resp_id, resp_prod} !== exp_e) begin
                  errors++;
                  $display("FAIL resp_data got id=%0d prod=%0h exp id=%0d prod=%0h",
                           resp_id, resp_prod, exp_e[65:64], exp_e[63:0]);
               end
            end
         end
         checks++;
         if (model_cred < 0 || model_cred > FD) begin
            errors++;
            $display("FAIL credit_range got=%0d exp 0..%0d", model_cred, FD);
         end
      end
   end

   task automatic set_ops(input int i, input logic [31:0] mr, input logic [31:0] mc);
      req_mr[32*i +: 32] = mr;
      req_mc[32*i +: 32] = mc;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      req_valid = '0;
      resp_ready = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy && n < 60);
      checks++;
      if (busy || sb.size() != 0) begin
         errors++;
         $display("FAIL drain_%s busy=%b pending=%0d exp busy=0 pending=0", name, busy, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      resp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'd2);
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b rv=%b busy=%b exp 0000/0/0", req_ready, resp_valid, busy);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release rv=%b busy=%b exp 0/0", resp_valid, busy);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      req_valid = 4'b0001;
      set_ops(0, 32'd3, 32'd5);
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready got=%b exp=0001", req_ready);
      end
      for (int c = 1; c <= LAT + 2; c++) begin
         @(posedge clk); #1;
         if (c == 1) req_valid = '0;
         @(negedge clk);
         checks++;
         if (resp_valid !== (c == LAT + 1)) begin
            errors++;
            $display("FAIL single_latency cycle=%0d rv=%b exp=%b", c, resp_valid, (c == LAT + 1));
         end
         if (c == LAT + 1) begin
            checks++;
            if (resp_id !== 2'd0 || resp_prod !== 64'd15) begin
               errors++;
               $display("FAIL single_result id=%0d prod=%0d exp id=0 prod=15", resp_id, resp_prod);
            end
         end
         if (c == LAT + 2) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL single_busy got=%b exp=0", busy);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      int p0;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'd2);
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      p0 = pop_cnt;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'(1 << (k % NREQ))) begin
            errors++;
            $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % NREQ)));
         end
         @(posedge clk); #1;
      end
      drain("rr");
      checks++;
      if (pop_cnt - p0 != 8) begin
         errors++;
         $display("FAIL rr_count got=%0d exp=8", pop_cnt - p0);
      end
   endtask

   task automatic test_backpressure();
      int a0;
      do_reset();
      resp_ready = 1'b0;
      req_valid = 4'b0010;
      set_ops(1, 32'd7, 32'd9);
      a0 = acc_cnt;
      repeat (10) begin @(posedge clk); #1; end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++;
         if (acc_cnt - a0 != FD || req_ready !== '0) begin
            errors++;
            $display("FAIL bp_stall accepts=%0d ready=%b exp %0d/0000", acc_cnt - a0, req_ready, FD);
         end
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_prod !== 64'd63) begin
            errors++;
            $display("FAIL bp_hold rv=%b id=%0d prod=%0d exp 1/1/63", resp_valid, resp_id, resp_prod);
         end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL bp_pop_cycle ready=%b exp=0000", req_ready);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_after_pop ready=%b exp=0010", req_ready);
      end
      repeat (4) begin
         @(posedge clk); #1;
         @(negedge clk); #1;
         checks++;
         if (req_ready !== '0) begin
            errors++;
            $display("FAIL bp_refill ready=%b exp=0000", req_ready);
         end
      end
      checks++;
      if (acc_cnt - a0 != FD + 1) begin
         errors++;
         $display("FAIL bp_accepts got=%0d exp=%0d", acc_cnt - a0, FD + 1);
      end
      // Credits at zero: first pop cycle cannot accept, afterwards pop+accept every cycle.
      @(posedge clk); #1;
      resp_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== ((k == 0) ? 4'b0000 : 4'b0010)) begin
            errors++;
            $display("FAIL bp_stream k=%0d ready=%b exp=%b", k, req_ready, ((k == 0) ? 4'b0000 : 4'b0010));
         end
         @(posedge clk); #1;
      end
      drain("bp");
   endtask

   task automatic test_wrap();
      do_reset();
      resp_ready = 1'b1;
      set_ops(0, 32'd11, 32'd13);
      set_ops(2, 32'd5, 32'd6);
      set_ops(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL wrap_setup ready=%b exp=0100", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 4'b1001;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_grant3 ready=%b exp=1000", req_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_grant0 ready=%b exp=0001", req_ready);
      end
      drain("wrap");
   endtask

   task automatic test_reset_midflight();
      do_reset();
      resp_ready = 1'b0;
      set_ops(0, 32'd21, 32'd2);
      set_ops(1, 32'd22, 32'd3);
      req_valid = 4'b0011;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (sb.size() != 2) begin
         errors++;
         $display("FAIL midflight_accepts got=%0d exp=2", sb.size());
      end
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midflight_in_reset rv=%b busy=%b exp 0/0", resp_valid, busy);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midflight_stale rv=%b busy=%b exp 0/0", resp_valid, busy);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_soak();
      int a0;
      int n;
      do_reset();
      a0 = acc_cnt;
      n = 0;
      while (acc_cnt - a0 < 10000 && n < 60000) begin
         req_valid = 4'($urandom);
         resp_ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (acc_cnt - a0 < 10000) begin
         errors++;
         $display("FAIL soak_budget accepts=%0d exp>=10000 cycles=%0d", acc_cnt - a0, n);
      end
      drain("soak");
   endtask

   initial begin
      req_valid = '0;
      req_mr = '0;
      req_mc = '0;
      resp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midflight();
      test_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
